// File: rtl/garage_occupancy_counter_if.sv
// Sensor and status bundle of the garage occupancy counter.
// The slave modport is the counter; the master modport is whatever drives the beams.
interface garage_occupancy_counter_if;
  logic       in_outer;
  logic       in_inner;
  logic       out_inner;
  logic       out_outer;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       entry_open;
  logic       car_in;
  logic       car_out;

  modport slave (
    input  in_outer, in_inner, out_inner, out_outer,
    output count, full, empty, entry_open, car_in, car_out
  );

  modport master (
    output in_outer, in_inner, out_inner, out_outer,
    input  count, full, empty, entry_open, car_in, car_out
  );
endinterface

// File: rtl/garage_occupancy_counter.sv
// Garage occupancy counter: two beam-pair lane FSMs feeding a saturating BCD digit.
// Optional input debounce filters are enabled by defining OCC_DEBOUNCE_EN.
module garage_occupancy_counter #(
  parameter int CAPACITY   = 9,
  parameter int DEB_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  garage_occupancy_counter_if.slave  bus
);

  localparam logic [3:0] CAP = 4'(CAPACITY);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FIRST  = 2'd1,
    S_BOTH   = 2'd2,
    S_SECOND = 2'd3
  } lane_state_t;

  if (CAPACITY < 1 || CAPACITY > 9 || DEB_CYCLES < 2 || DEB_CYCLES > 255) begin : g_bad_param
    $error("garage_occupancy_counter: CAPACITY or DEB_CYCLES out of range");
  end

  // Bit order: [3]=in_outer [2]=in_inner [1]=out_inner [0]=out_outer
  logic [3:0] w_raw;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_clean;

  assign w_raw = {bus.in_outer, bus.in_inner, bus.out_inner, bus.out_outer};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef OCC_DEBOUNCE_EN
  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  for (genvar gi = 0; gi < 4; gi++) begin : g_deb
    logic [7:0] r_deb_cnt;
    logic       r_deb_out;

    // Output follows the input only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_deb_cnt <= '0;
        r_deb_out <= 1'b0;
      end else if (r_sync2[gi] == r_deb_out) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        r_deb_cnt <= '0;
        r_deb_out <= r_sync2[gi];
      end else begin
        r_deb_cnt <= r_deb_cnt + 8'd1;
      end
    end

    assign w_clean[gi] = r_deb_out;
  end
`else
  assign w_clean = r_sync2;
`endif

  // Lane 0 = entry (street beam first), lane 1 = exit (garage beam first).
  logic       r_full;
  logic       r_empty;
  logic       r_entry_open;
  logic [3:0] r_count;
  logic [3:0] w_count_next;
  logic [1:0] w_first;
  logic [1:0] w_second;
  logic [1:0] w_allow;
  logic [1:0] w_pulse;

  assign w_first  = {w_clean[1], w_clean[3]};
  assign w_second = {w_clean[0], w_clean[2]};
  assign w_allow  = {1'b1, ~r_full};

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    lane_state_t r_state;
    lane_state_t w_state_next;
    logic        w_done;
    logic        r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= S_IDLE;
        r_pulse <= 1'b0;
      end else begin
        r_state <= w_state_next;
        r_pulse <= w_done;
      end
    end

    always_comb begin
      w_state_next = r_state;
      w_done       = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_first[gi] && !w_second[gi] && w_allow[gi])
            w_state_next = S_FIRST;
        end
        S_FIRST: begin
          if (w_first[gi] && w_second[gi])
            w_state_next = S_BOTH;
          else if (!w_first[gi] && !w_second[gi])
            w_state_next = S_IDLE;
        end
        S_BOTH: begin
          if (!w_first[gi] && w_second[gi])
            w_state_next = S_SECOND;
          else if (w_first[gi] && !w_second[gi])
            w_state_next = S_FIRST;
        end
        S_SECOND: begin
          if (!w_first[gi] && !w_second[gi]) begin
            w_state_next = S_IDLE;
            w_done       = 1'b1;
          end else if (w_first[gi] && w_second[gi]) begin
            w_state_next = S_BOTH;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end

    assign w_pulse[gi] = r_pulse;
  end

  // Simultaneous entry and exit cancel; otherwise step and saturate.
  always_comb begin
    w_count_next = r_count;
    case (w_pulse)
      2'b01:   w_count_next = (r_count >= CAP)  ? CAP   : r_count + 4'd1;
      2'b10:   w_count_next = (r_count == 4'd0) ? 4'd0  : r_count - 4'd1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= 4'd0;
      r_full       <= (CAP == 4'd0);
      r_empty      <= 1'b1;
      r_entry_open <= (CAP != 4'd0);
    end else begin
      r_count      <= w_count_next;
      r_full       <= (w_count_next == CAP);
      r_empty      <= (w_count_next == 4'd0);
      r_entry_open <= (w_count_next != CAP);
    end
  end

  assign bus.count      = r_count;
  assign bus.full       = r_full;
  assign bus.empty      = r_empty;
  assign bus.entry_open = r_entry_open;
  assign bus.car_in     = w_pulse[0];
  assign bus.car_out    = w_pulse[1];

endmodule

// File: tb/tb_garage_occupancy_counter.sv
// Scoreboard bench for garage_occupancy_counter: stimulus pushes expected pulses,
// a negedge monitor pops and compares them along with the resulting count/flags.
module tb_garage_occupancy_counter;

  localparam int CAPACITY = 9;
`ifdef OCC_DEBOUNCE_EN
  localparam int EXTRA = 4;
`else
  localparam int EXTRA = 0;
`endif

  logic clk;
  logic rst_n;
  garage_occupancy_counter_if bus();

  garage_occupancy_counter #(.CAPACITY(CAPACITY), .DEB_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic ci;
    logic co;
    int   cnt;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_count  = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // v = {in_outer, in_inner, out_inner, out_outer}
  task automatic drive(input logic [3:0] v);
    bus.in_outer  = v[3];
    bus.in_inner  = v[2];
    bus.out_inner = v[1];
    bus.out_outer = v[0];
  endtask

  task automatic step(input logic [3:0] v, input int hold);
    drive(v);
    repeat (hold) @(negedge clk);
  endtask

  function automatic int rhold();
    return int'($urandom_range(1, 4)) + EXTRA;
  endfunction

  task automatic settle();
    repeat (6 + EXTRA) @(negedge clk);
  endtask

  // Reference: an entry is accepted only if the garage is not full when it starts.
  task automatic expect_entry();
    exp_t e;
    if (m_count < CAPACITY) begin
      m_count = m_count + 1;
      e.ci = 1'b1; e.co = 1'b0; e.cnt = m_count;
      q.push_back(e);
    end
  endtask

  task automatic expect_exit();
    exp_t e;
    m_count = (m_count > 0) ? m_count - 1 : 0;
    e.ci = 1'b0; e.co = 1'b1; e.cnt = m_count;
    q.push_back(e);
  endtask

  task automatic entry_pass();
    expect_entry();
    step(4'b1000, rhold()); step(4'b1100, rhold()); step(4'b0100, rhold()); step(4'b0000, 1);
    settle();
    $display("entry  -> model count=%0d dut count=%0d", m_count, bus.count);
  endtask

  task automatic exit_pass();
    expect_exit();
    step(4'b0010, rhold()); step(4'b0011, rhold()); step(4'b0001, rhold()); step(4'b0000, 1);
    settle();
    $display("exit   -> model count=%0d dut count=%0d", m_count, bus.count);
  endtask

  task automatic reversal(input bit lane);
    if (!lane) begin
      step(4'b1000, rhold()); step(4'b1100, rhold()); step(4'b1000, rhold()); step(4'b0000, 1);
    end else begin
      step(4'b0010, rhold()); step(4'b0011, rhold()); step(4'b0010, rhold()); step(4'b0000, 1);
    end
    settle();
    $display("revers lane=%0d -> model count=%0d dut count=%0d", lane, m_count, bus.count);
  endtask

  task automatic wrong_dir();
    step(4'b0100, rhold()); step(4'b1100, rhold()); step(4'b1000, rhold()); step(4'b0000, 1);
    settle();
    $display("wrong  -> model count=%0d dut count=%0d", m_count, bus.count);
  endtask

  // Monitor: one scoreboard pop per observed pulse, then the following cycle's state.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.car_in || bus.car_out)) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", {bus.car_in, bus.car_out}, 0);
        end else begin
          e = q.pop_front();
          chk("car_in", int'(bus.car_in), int'(e.ci));
          chk("car_out", int'(bus.car_out), int'(e.co));
          @(negedge clk);
          chk("pulse_width", {bus.car_in, bus.car_out}, 0);
          chk("count", int'(bus.count), e.cnt);
          chk("full", int'(bus.full), int'(e.cnt == CAPACITY));
          chk("empty", int'(bus.empty), int'(e.cnt == 0));
          chk("entry_open", int'(bus.entry_open), int'(e.cnt != CAPACITY));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(4'b0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_entry_open", int'(bus.entry_open), 1);
    chk("rst_pulses", {bus.car_in, bus.car_out}, 0);

    // Reset while the entry FSM sits in BOTH; afterwards the lane must be back in IDLE.
    step(4'b1000, 3 + EXTRA);
    step(4'b1100, 3 + EXTRA);
    #2 rst_n = 1'b0;
    drive(4'b0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // From BOTH this would complete an entry; from IDLE nothing happens.
    step(4'b0100, 3 + EXTRA); step(4'b0000, 1);
    settle();
    chk("midrst_count", int'(bus.count), 0);
    $display("midrst -> model count=%0d dut count=%0d", m_count, bus.count);

    // Directed entry with latency check from the final clear.
    expect_entry();
    step(4'b1000, 5 + EXTRA); step(4'b1100, 5 + EXTRA); step(4'b0100, 5 + EXTRA);
    drive(4'b0000);
    @(posedge clk);
    repeat (2 + EXTRA) @(posedge clk);
    #1 chk("lat_before", int'(bus.count), 0);
    @(posedge clk);
    #1 chk("lat_after", int'(bus.count), 1);
    settle();
    $display("latent -> model count=%0d dut count=%0d", m_count, bus.count);

    // Fill to capacity, refuse one more, then one exit.
    while (m_count < CAPACITY) entry_pass();
    chk("cap_count", int'(bus.count), CAPACITY);
    chk("cap_full", int'(bus.full), 1);
    chk("cap_entry_open", int'(bus.entry_open), 0);
    entry_pass();
    chk("refused_count", int'(bus.count), CAPACITY);
    exit_pass();
    chk("after_exit_full", int'(bus.full), 0);

    // Drain, then exit at zero.
    while (m_count > 0) exit_pass();
    exit_pass();
    chk("zero_exit_count", int'(bus.count), 0);

    reversal(1'b0);
    reversal(1'b1);
    chk("reversal_count", int'(bus.count), 0);

    // Entry and exit completing on the same edge at count 3.
    repeat (3) entry_pass();
    begin
      exp_t e;
      e.ci = 1'b1; e.co = 1'b1; e.cnt = m_count;
      q.push_back(e);
    end
    step(4'b1010, 3 + EXTRA); step(4'b1111, 3 + EXTRA); step(4'b0101, 3 + EXTRA); step(4'b0000, 1);
    settle();
    chk("same_edge_count", int'(bus.count), 3);
    $display("both   -> model count=%0d dut count=%0d", m_count, bus.count);

`ifdef OCC_DEBOUNCE_EN
    // A short in_outer glitch must not arm the entry lane.
    step(4'b1000, 2);
    step(4'b0100, 3 + EXTRA); step(4'b1100, 3 + EXTRA); step(4'b0100, 3 + EXTRA); step(4'b0000, 1);
    settle();
    chk("glitch_count", int'(bus.count), m_count);
    $display("glitch -> model count=%0d dut count=%0d", m_count, bus.count);
`endif

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0, 1: entry_pass();
        2:    exit_pass();
        3:    reversal(1'($urandom_range(0, 1)));
        default: wrong_dir();
      endcase
    end
    chk("final_count", int'(bus.count), m_count);
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/garage_occupancy_counter.md
# garage_occupancy_counter

Upstream stage of the garage display path. It watches the entry-lane and exit-lane beam sensors and recognises complete car passages with a per-lane direction state machine. It keeps the number of parked cars as a BCD digit, which drives the 7-segment decoder directly (bit 3 = A … bit 0 = D). It also raises full/empty indications and refuses entries once capacity is reached.

## Interface
Parameters:
- CAPACITY, default 9: maximum cars; legal range 1–9 (single BCD digit).
- DEB_CYCLES, default 4: stable-sample count; used only when OCC_DEBOUNCE_EN is defined; legal range 2–255.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_outer  in  1  entry lane, street-side beam; 1 = beam blocked.
- in_inner  in  1  entry lane, garage-side beam; 1 = blocked.
- out_inner  in  1  exit lane, garage-side beam; 1 = blocked.
- out_outer  in  1  exit lane, street-side beam; 1 = blocked.
- count  out  4  occupancy in BCD, 0..CAPACITY; count[3] = A, count[0] = D.
- full  out  1  1 when count == CAPACITY.
- empty  out  1  1 when count == 0.
- entry_open  out  1  entry barrier enable; equals ~full, registered.
- car_in  out  1  one-cycle pulse per accepted entry.
- car_out  out  1  one-cycle pulse per accepted exit.

## Operation
- Every sensor passes through a 2-flop synchronizer before any logic uses it. All further references are to synchronized values.
- Each lane has one FSM with states IDLE, FIRST, BOTH, SECOND.
  - "First" is the street-side beam for entry and the garage-side beam for exit. "Second" is the other beam in the same lane.
  - IDLE → FIRST when first=1 and second=0. On the entry lane this transition also requires full=0.
  - FIRST → BOTH when both beams are 1. FIRST → IDLE when both are 0 (the car backed out).
  - BOTH → SECOND when first=0 and second=1. BOTH → FIRST when first=1 and second=0.
  - SECOND → IDLE with the lane pulse when both are 0. SECOND → BOTH when both are 1.
  - IDLE with second=1 (wrong direction) stays IDLE and produces no pulse.
- Counter rules:
  - car_in only → count+1, saturating at CAPACITY.
  - car_out only → count−1, saturating at 0.
  - car_in and car_out in the same cycle → count unchanged.
  - count never leaves the range 0..CAPACITY.
- An entry FSM already past IDLE finishes its passage even if full rises meanwhile. The saturating counter absorbs the result.
- full, empty and entry_open are registered from the next count value, so they change on the same edge as count.

## Timing
- Reset values: count=0, full=0 (1 if CAPACITY==0 is ever forced), empty=1, entry_open=1, car_in=0, car_out=0. Both FSMs reset to IDLE and all synchronizers to 0.
- Reset is asynchronous. Asserting it mid-passage aborts the passage, and no pulse is emitted.
- Latency, debounce off:
  - A sensor change sampled at edge k is visible to the FSM after edge k+1.
  - The FSM changes state at edge k+2.
  - The car_in/car_out pulse is high from edge k+2 to edge k+3.
  - count, full, empty and entry_open update at edge k+3.
- Each pulse lasts exactly one cycle. At most one passage completes per lane per 4 cycles.

## Configuration
- OCC_DEBOUNCE_EN defined:
  - Each synchronized sensor feeds a filter that updates its output only after DEB_CYCLES consecutive equal samples.
  - This adds DEB_CYCLES cycles of latency.
  - Glitches shorter than DEB_CYCLES are ignored.
- OCC_DEBOUNCE_EN undefined: the filters are absent; only the 2-flop synchronizer is used.

## Test plan
- Reset → count=0000, empty=1, full=0, entry_open=1. Then assert rst_n low while the entry FSM is in BOTH: on release the FSM is IDLE, count=0 and no car_in has occurred.
- Entry sequence in_outer=1; both=1; in_inner only; both=0, each step held 5 cycles → one car_in pulse and count=0001 three cycles after the final clear (debounce off).
- Nine entries with CAPACITY=9 → count=1001, full=1, entry_open=0. A tenth entry attempt gives no car_in and count stays 1001. One exit then gives count=1000 and full=0.
- Reversal: in_outer=1, then both=1, then in_outer only, then both=0 → no car_in. Exit at count=0 → car_out pulses and count stays 0000.
- Entry and exit completed on the same edge with count=0011 → both pulses high and count stays 0011.
- With OCC_DEBOUNCE_EN and DEB_CYCLES=4: a 2-cycle glitch on in_outer → entry FSM stays IDLE. A valid entry → count increments 7 cycles after the final clear.
